controlador_memoria: RTL and testbench
======================================

// Module: controlador_memoria
// PURPOSE
//  Arbiter/mux between four masters (Validador, Colisor, Pontuacao, VGA) and two
//  external single-port player RAMs (jogadorUm, jogadorDois; 64-bit words, 5-bit addr).
//  Drives one shared addr/data bus plus per-player write enables, and routes read data
//  back to the requesting master. Sits between game logic/VGA and the board RAMs.
// PARAMETERS
//  DATA_W  64  word width (one board row)
//  ADDR_W  5   address width (board rows 0..10 used; 11..31 passed through unchanged)
// PORTS
//  clk                       in  1   system clock
//  resetGeral                in  1   reset, synchronous, active-high
//  data_memoria_jogadorUm    in  64  RAM P1 read data (valid 1 cycle after addr)
//  data_memoria_jogadorDois  in  64  RAM P2 read data (valid 1 cycle after addr)
//  readyValidador            in  1   validador request (read/write phase)
//  enableValidador           in  1   validador active (read sweep)
//  validador_wrep1/_wrep2    in  1   validador write strobe P1/P2
//  validadorJogador          in  1   validador read target: 0=P1, 1=P2
//  validador_addr            in  5   validador address
//  validador_data             in  64  validador write data
//  readyColisor              in  1   colisor request
//  colisor_wrep1/_wrep2      in  1   colisor write strobe P1/P2
//  jogadorColisor            in  1   colisor read target: 0=P1, 1=P2
//  colisor_addr              in  5   colisor address
//  colisor_data              in  64  colisor write data
//  readyPontuacao            in  1   pontuacao read request
//  pontuacao_addr            in  5   pontuacao address
//  jogadorPontuacao          in  1   pontuacao read target
//  vga_readAddr              in  5   VGA address (default owner, read only)
//  jogadorVGA                in  1   VGA read target
//  dataReadValidador         out 64  read data to validador
//  dataReadColisor           out 64  read data to colisor AND pontuacao
//  dataReadVGA               out 64  read data to VGA
//  data                      out 64  shared RAM write data
//  addr                      out 5   shared RAM address
//  wrenP1 / wrenP2           out 1   RAM write enables
// BEHAVIOUR
//  - Grant (combinational, fixed priority): VAL if readyValidador|enableValidador;
//    else COL if readyColisor; else PON if readyPontuacao; else VGA.
//  - addr = granted master's address; data = validador_data (VAL), colisor_data (COL),
//    else 64'h0. Combinational, same cycle as grant.
//  - wrenP1 = VAL&validador_wrep1 | COL&colisor_wrep1; wrenP2 likewise with _wrep2.
//    PON/VGA never write. Both strobes high -> both RAMs written with same data.
//  - Strobes from non-granted master are ignored (dropped, not queued).
//  - Read path: register {grant, jogador bit} each cycle; next cycle select
//    data_memoria_jogadorUm (bit=0) or _Dois (bit=1) and register it into the
//    output of the master granted the previous cycle (VAL->dataReadValidador,
//    COL/PON->dataReadColisor, VGA->dataReadVGA). Total read latency 2 clk
//    from addr presentation to dataRead* update. Other dataRead* outputs hold.
//  - Write cycles also load read-back into the owner's dataRead* (read-during-write
//    value is whatever RAM returns; no forwarding).
//  - Reset: grant pipeline = VGA, all dataRead* = 0; while resetGeral high,
//    wrenP1=wrenP2=0, addr=0, data=0. Reset mid-request aborts it; no pending state.
// STRUCTURE
//  - Package memctl_pkg: DATA_W, ADDR_W, typedef enum {G_VGA,G_VAL,G_COL,G_PON} grant_t.
//  - One sub-module memctl_arbiter (priority grant + bus mux); top holds read pipeline.
// TESTING
//  1 Reset, RAMs all 0, no requests -> addr=vga_readAddr, wrenP1=wrenP2=0, dataRead*=0.
//  2 VGA sweep addr 0..10, jogadorVGA=0, RAM P1[i]=i -> dataReadVGA=i two clk later.
//  3 enableValidador=1, validadorJogador=0, sweep 0..10 -> addr=validador_addr,
//    dataReadValidador follows P1, dataReadVGA holds.
//  4 readyValidador=1, wrep1=1, addr=7, data=64'hFFFF_FFFF_FFFF_FFFF -> wrenP1=1,
//    data=all ones, P1[7] reads back all ones.
//  5 readyColisor & readyValidador, colisor_wrep2=1 -> VAL granted, wrenP2=0;
//    drop readyValidador -> wrenP2=1, addr=colisor_addr.
//  6 readyPontuacao, jogadorPontuacao=1, addr=3 -> dataReadColisor=P2[3] after 2 clk.

Source files
------------

// File: rtl/memctl_pkg.sv
// Shared widths, grant encoding and bus payload for the board-RAM controller.
package memctl_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [1:0] {
        G_VGA = 2'd0,
        G_VAL = 2'd1,
        G_COL = 2'd2,
        G_PON = 2'd3
    } grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wren_p1;
        logic              wren_p2;
    } bus_t;

endpackage

// File: rtl/memctl_arbiter.sv
// Fixed-priority grant (VAL > COL > PON > VGA) and the shared RAM bus mux.
module memctl_arbiter
    import memctl_pkg::*;
(
    input  logic              rst,
    input  logic              ready_val,
    input  logic              enable_val,
    input  logic              val_wrep1,
    input  logic              val_wrep2,
    input  logic              val_jogador,
    input  logic [ADDR_W-1:0] val_addr,
    input  logic [DATA_W-1:0] val_data,
    input  logic              ready_col,
    input  logic              col_wrep1,
    input  logic              col_wrep2,
    input  logic              col_jogador,
    input  logic [ADDR_W-1:0] col_addr,
    input  logic [DATA_W-1:0] col_data,
    input  logic              ready_pon,
    input  logic              pon_jogador,
    input  logic [ADDR_W-1:0] pon_addr,
    input  logic              vga_jogador,
    input  logic [ADDR_W-1:0] vga_addr,
    output grant_t            grant_c,
    output logic              jogador_c,
    output bus_t              bus_c
);

    // VGA owns the bus whenever nobody else asks for it
    always_comb begin
        grant_c = G_VGA;
        if (ready_val || enable_val) begin
            grant_c = G_VAL;
        end else if (ready_col) begin
            grant_c = G_COL;
        end else if (ready_pon) begin
            grant_c = G_PON;
        end
    end

    // Strobes of a master that does not hold the grant are simply dropped
    always_comb begin
        bus_c     = '0;
        jogador_c = vga_jogador;
        bus_c.addr = vga_addr;
        case (grant_c)
            G_VAL: begin
                bus_c.addr    = val_addr;
                bus_c.data    = val_data;
                bus_c.wren_p1 = val_wrep1;
                bus_c.wren_p2 = val_wrep2;
                jogador_c     = val_jogador;
            end
            G_COL: begin
                bus_c.addr    = col_addr;
                bus_c.data    = col_data;
                bus_c.wren_p1 = col_wrep1;
                bus_c.wren_p2 = col_wrep2;
                jogador_c     = col_jogador;
            end
            G_PON: begin
                bus_c.addr = pon_addr;
                jogador_c  = pon_jogador;
            end
            default: begin
                bus_c.addr = vga_addr;
                jogador_c  = vga_jogador;
            end
        endcase
        if (rst) begin
            bus_c = '0;
        end
    end

endmodule

// File: rtl/controlador_memoria.sv
// Shares two single-port player RAMs between four masters and routes read data
// back to whichever master held the bus when the address was presented.
module controlador_memoria
    import memctl_pkg::*;
(
    input  logic              clk,
    input  logic              resetGeral,
    input  logic [DATA_W-1:0] data_memoria_jogadorUm,
    input  logic [DATA_W-1:0] data_memoria_jogadorDois,
    input  logic              readyValidador,
    input  logic              enableValidador,
    input  logic              validador_wrep1,
    input  logic              validador_wrep2,
    input  logic              validadorJogador,
    input  logic [ADDR_W-1:0] validador_addr,
    input  logic [DATA_W-1:0] validador_data,
    input  logic              readyColisor,
    input  logic              colisor_wrep1,
    input  logic              colisor_wrep2,
    input  logic              jogadorColisor,
    input  logic [ADDR_W-1:0] colisor_addr,
    input  logic [DATA_W-1:0] colisor_data,
    input  logic              readyPontuacao,
    input  logic [ADDR_W-1:0] pontuacao_addr,
    input  logic              jogadorPontuacao,
    input  logic [ADDR_W-1:0] vga_readAddr,
    input  logic              jogadorVGA,
    output logic [DATA_W-1:0] dataReadValidador,
    output logic [DATA_W-1:0] dataReadColisor,
    output logic [DATA_W-1:0] dataReadVGA,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              wrenP1,
    output logic              wrenP2
);

    grant_t            grant_c;
    grant_t            grant_q;
    logic              jogador_c;
    logic              jogador_q;
    bus_t              bus_c;
    logic [DATA_W-1:0] read_word_c;

    memctl_arbiter u_arbiter (
        .rst         (resetGeral),
        .ready_val   (readyValidador),
        .enable_val  (enableValidador),
        .val_wrep1   (validador_wrep1),
        .val_wrep2   (validador_wrep2),
        .val_jogador (validadorJogador),
        .val_addr    (validador_addr),
        .val_data    (validador_data),
        .ready_col   (readyColisor),
        .col_wrep1   (colisor_wrep1),
        .col_wrep2   (colisor_wrep2),
        .col_jogador (jogadorColisor),
        .col_addr    (colisor_addr),
        .col_data    (colisor_data),
        .ready_pon   (readyPontuacao),
        .pon_jogador (jogadorPontuacao),
        .pon_addr    (pontuacao_addr),
        .vga_jogador (jogadorVGA),
        .vga_addr    (vga_readAddr),
        .grant_c     (grant_c),
        .jogador_c   (jogador_c),
        .bus_c       (bus_c)
    );

    // The RAM bus is combinational so the address reaches the RAM in the grant cycle
    assign addr   = bus_c.addr;
    assign data   = bus_c.data;
    assign wrenP1 = bus_c.wren_p1;
    assign wrenP2 = bus_c.wren_p2;

    assign read_word_c = jogador_q ? data_memoria_jogadorDois : data_memoria_jogadorUm;

    // Stage 1 remembers who asked and which board; stage 2 lands the RAM word
    always_ff @(posedge clk) begin
        if (resetGeral) begin
            grant_q           <= G_VGA;
            jogador_q         <= 1'b0;
            dataReadValidador <= '0;
            dataReadColisor   <= '0;
            dataReadVGA       <= '0;
        end else begin
            grant_q   <= grant_c;
            jogador_q <= jogador_c;
            case (grant_q)
                G_VAL:        dataReadValidador <= read_word_c;
                G_COL, G_PON: dataReadColisor   <= read_word_c;
                default:      dataReadVGA       <= read_word_c;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_memoria.sv
// Directed bench for controlador_memoria with two behavioural synchronous RAMs.
module tb_controlador_memoria;

    localparam int M_VGA = 0;
    localparam int M_VAL = 1;
    localparam int M_COL = 2;
    localparam int M_PON = 3;
    localparam logic [63:0] VD   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] CD   = 64'h5555_6666_7777_8888;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetGeral;
    logic [63:0] q1, q2;
    logic        rv, ev, vw1, vw2, vj;
    logic [4:0]  va;
    logic [63:0] vd;
    logic        rc, cw1, cw2, cj;
    logic [4:0]  ca;
    logic [63:0] cd;
    logic        rp, pj;
    logic [4:0]  pa;
    logic [4:0]  ga;
    logic        gj;
    logic [63:0] dataReadValidador, dataReadColisor, dataReadVGA, data;
    logic [4:0]  addr;
    logic        wrenP1, wrenP2;
    logic        ram_init;

    int checks = 0;
    int errors = 0;

    controlador_memoria dut (
        .clk                      (clk),
        .resetGeral               (resetGeral),
        .data_memoria_jogadorUm   (q1),
        .data_memoria_jogadorDois (q2),
        .readyValidador           (rv),
        .enableValidador          (ev),
        .validador_wrep1          (vw1),
        .validador_wrep2          (vw2),
        .validadorJogador         (vj),
        .validador_addr           (va),
        .validador_data           (vd),
        .readyColisor             (rc),
        .colisor_wrep1            (cw1),
        .colisor_wrep2            (cw2),
        .jogadorColisor           (cj),
        .colisor_addr             (ca),
        .colisor_data             (cd),
        .readyPontuacao           (rp),
        .pontuacao_addr           (pa),
        .jogadorPontuacao         (pj),
        .vga_readAddr             (ga),
        .jogadorVGA               (gj),
        .dataReadValidador        (dataReadValidador),
        .dataReadColisor          (dataReadColisor),
        .dataReadVGA              (dataReadVGA),
        .data                     (data),
        .addr                     (addr),
        .wrenP1                   (wrenP1),
        .wrenP2                   (wrenP2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] p1(input int i);
        return 64'(i);
    endfunction

    function automatic logic [63:0] p2(input int i);
        return 64'hB2B2_0000_0000_0000 + 64'(i * 3 + 1);
    endfunction

    // Player RAMs: registered read, old data returned on a write cycle
    logic [63:0] mem1 [32];
    logic [63:0] mem2 [32];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 32; i++) begin
                mem1[i] <= p1(i);
                mem2[i] <= p2(i);
            end
        end else begin
            if (wrenP1) mem1[addr] <= data;
            if (wrenP2) mem2[addr] <= data;
        end
        q1 <= mem1[addr];
        q2 <= mem2[addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        rv = 0; ev = 0; vw1 = 0; vw2 = 0; vj = 0; va = 0; vd = VD;
        rc = 0; cw1 = 0; cw2 = 0; cj = 0; ca = 0; cd = CD;
        rp = 0; pj = 0; pa = 0;
    endtask

    task automatic check_bus(input string tag, input logic [4:0] a, input logic [63:0] d,
                             input logic w1, input logic w2);
        chk({tag, "_addr"}, 64'(addr), 64'(a));
        chk({tag, "_data"}, data, d);
        chk({tag, "_wrenP1"}, 64'(wrenP1), 64'(w1));
        chk({tag, "_wrenP2"}, 64'(wrenP2), 64'(w2));
    endtask

    // One-shot read by master m; result lands two edges after the address
    task automatic read_check(input string name, input int m, input logic jog,
                              input logic [4:0] a, input logic [63:0] exp);
        @(negedge clk);
        idle();
        case (m)
            M_VAL:   begin rv = 1; vj = jog; va = a; end
            M_COL:   begin rc = 1; cj = jog; ca = a; end
            M_PON:   begin rp = 1; pj = jog; pa = a; end
            default: begin gj = jog; ga = a; end
        endcase
        #1 chk({name, "_addr"}, 64'(addr), 64'(a));
        @(negedge clk);
        idle();
        @(negedge clk);
        case (m)
            M_VAL:   chk(name, dataReadValidador, exp);
            M_VGA:   chk(name, dataReadVGA, exp);
            default: chk(name, dataReadColisor, exp);
        endcase
    endtask

    typedef struct {
        logic rv, ev, rc, rp, vw1, vw2, cw1, cw2;
        logic [4:0]  va, ca, pa, ga;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic        e_w1, e_w2;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0,0,0,0, 0,0,0,0, 5'd1,  5'd2,  5'd3,  5'd9,  5'd9,  64'h0, 0, 0};
        vecs[1] = '{0,1,0,0, 1,0,0,0, 5'd4,  5'd2,  5'd3,  5'd9,  5'd4,  VD,    1, 0};
        vecs[2] = '{1,0,0,0, 1,1,0,0, 5'd11, 5'd2,  5'd3,  5'd9,  5'd11, VD,    1, 1};
        vecs[3] = '{1,0,1,0, 0,0,0,1, 5'd12, 5'd5,  5'd3,  5'd9,  5'd12, VD,    0, 0};
        vecs[4] = '{0,0,1,0, 0,0,0,1, 5'd12, 5'd5,  5'd3,  5'd9,  5'd5,  CD,    0, 1};
        vecs[5] = '{0,0,1,1, 0,0,1,0, 5'd12, 5'd20, 5'd3,  5'd9,  5'd20, CD,    1, 0};
        vecs[6] = '{0,0,0,1, 1,0,1,0, 5'd12, 5'd20, 5'd31, 5'd9,  5'd31, 64'h0, 0, 0};
        vecs[7] = '{0,0,0,0, 1,1,1,1, 5'd12, 5'd20, 5'd31, 5'd17, 5'd17, 64'h0, 0, 0};

        // Reset with a write request pending: bus must stay quiet
        idle();
        ga = 5'd6; gj = 0;
        resetGeral = 1; ram_init = 1;
        rv = 1; vw1 = 1; va = 5'd9;
        repeat (3) @(negedge clk);
        #1 check_bus("reset_bus", 5'd0, 64'h0, 0, 0);
        chk("reset_val", dataReadValidador, 64'h0);
        chk("reset_col", dataReadColisor, 64'h0);
        chk("reset_vga", dataReadVGA, 64'h0);
        @(negedge clk);
        idle();
        resetGeral = 0; ram_init = 0;
        #1 chk("idle_addr_vga", 64'(addr), 64'd6);
        chk("idle_vga_zero", dataReadVGA, 64'h0);

        // Combinational grant/bus table, strobes removed before the next edge
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rv = vecs[i].rv; ev = vecs[i].ev; rc = vecs[i].rc; rp = vecs[i].rp;
            vw1 = vecs[i].vw1; vw2 = vecs[i].vw2; cw1 = vecs[i].cw1; cw2 = vecs[i].cw2;
            va = vecs[i].va; ca = vecs[i].ca; pa = vecs[i].pa; ga = vecs[i].ga;
            #1 check_bus($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_data,
                         vecs[i].e_w1, vecs[i].e_w2);
            idle();
        end

        // VGA sweep over board rows of player 1
        gj = 0;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (j >= 2) chk($sformatf("vga_sweep%0d", j - 2), dataReadVGA, p1(j - 2));
            if (j <= 10) ga = 5'(j);
        end

        // Validador sweep; VGA output must hold its last row
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                chk($sformatf("val_sweep%0d", j - 2), dataReadValidador, p1(j - 2));
                chk("vga_hold", dataReadVGA, p1(10));
            end
            if (j <= 10) begin
                ev = 1; vj = 0; va = 5'(j); ga = 5'd3;
                #1 chk("val_sweep_addr", 64'(addr), 64'(j));
            end
        end
        @(negedge clk);
        idle();
        ga = 5'd10;

        read_check("val_p2", M_VAL, 1, 5'd6, p2(6));
        read_check("col_p2", M_COL, 1, 5'd8, p2(8));
        read_check("col_p1", M_COL, 0, 5'd4, p1(4));
        read_check("pon_p2", M_PON, 1, 5'd3, p2(3));
        read_check("vga_p2", M_VGA, 1, 5'd2, p2(2));
        gj = 0; ga = 5'd10;

        // Validador writes all ones into P1 row 7
        @(negedge clk);
        rv = 1; vw1 = 1; va = 5'd7; vd = ONES;
        #1 check_bus("val_write", 5'd7, ONES, 1, 0);
        @(negedge clk);
        idle();
        read_check("val_rb_p1", M_VAL, 0, 5'd7, ONES);
        read_check("pon_rb_p2", M_PON, 1, 5'd7, p2(7));

        // Colisor write blocked by validador, then granted
        @(negedge clk);
        rv = 1; va = 5'd2; rc = 1; cw2 = 1; ca = 5'd5; cd = CD;
        #1 check_bus("col_blocked", 5'd2, VD, 0, 0);
        @(negedge clk);
        rv = 0;
        #1 check_bus("col_granted", 5'd5, CD, 0, 1);
        @(negedge clk);
        idle();
        read_check("col_rb_p2", M_COL, 1, 5'd5, CD);
        read_check("col_rb_p1", M_COL, 0, 5'd5, p1(5));

        // Reset in the middle of a colisor write aborts it
        @(negedge clk);
        rc = 1; cw1 = 1; ca = 5'd9; resetGeral = 1;
        #1 check_bus("midreset_bus", 5'd0, 64'h0, 0, 0);
        @(negedge clk);
        chk("midreset_col", dataReadColisor, 64'h0);
        chk("midreset_val", dataReadValidador, 64'h0);
        chk("midreset_vga", dataReadVGA, 64'h0);
        idle();
        resetGeral = 0;
        read_check("midreset_p1_9", M_PON, 0, 5'd9, p1(9));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
